// File: rtl/fsincos_pkg.sv
// ============================================================================
// Module  : fsincos_pkg
// Brief   : Shared constants for the fsincos coefficient ROM and its arbiter.
//           Optional macro COEF_ARB_RSP_REG_EN selects the two-cycle response.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fsincos_pkg;

    localparam int ROM_ADDR_W = 5;
    localparam int ROM_DATA_W = 168;
    localparam int ROM_DEPTH  = 32;

`ifdef COEF_ARB_RSP_REG_EN
    localparam int COEF_ARB_LAT = 2;
`else
    localparam int COEF_ARB_LAT = 1;
`endif

    // Pointer/index width that stays legal for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coef_rom_arbiter_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter: searches req from ptr upward,
//           wrapping, and returns a one-hot grant (gated by en) and its index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import fsincos_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]              req,
    input  logic [ptr_width(N)-1:0]   ptr,
    input  logic                      en,
    output logic [N-1:0]              gnt,
    output logic [ptr_width(N)-1:0]   idx
);

    localparam int PTR_W = ptr_width(N);

    logic w_found;

    // idx is reported even when en is low; only gnt is gated.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[(int'(ptr) + i) % N]) begin
                w_found = 1'b1;
                idx     = PTR_W'((int'(ptr) + i) % N);
            end
        end
        if (en && w_found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/coef_rom_arbiter.sv
// ============================================================================
// Module  : coef_rom_arbiter
// Brief   : Round-robin sharing of one registered-address coefficient ROM;
//           returns each word with its requester strobe and tag.
//           Macro COEF_ARB_RSP_REG_EN adds one response register stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module coef_rom_arbiter
    import fsincos_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W,
    parameter int TAG_W  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [N_REQ*TAG_W-1:0]  i_req_tag,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic                    i_hold,
    output logic [ADDR_W-1:0]       o_mem_addr,
    output logic                    o_mem_valid,
    input  logic [DATA_W-1:0]       i_mem_data,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic [TAG_W-1:0]        o_rsp_tag,
    output logic [DATA_W-1:0]       o_rsp_data,
    output logic                    o_busy
);

    localparam int PTR_W = ptr_width(N_REQ);

    logic [PTR_W-1:0] r_ptr_q;
    logic [PTR_W-1:0] w_ptr_d;
    logic [PTR_W-1:0] w_idx;
    logic [N_REQ-1:0] w_gnt;
    logic             w_arb_en;
    logic             w_accept;

    logic [N_REQ-1:0] r_s1_vld_q;
    logic [N_REQ-1:0] w_s1_vld_d;
    logic [TAG_W-1:0] r_s1_tag_q;
    logic [TAG_W-1:0] w_s1_tag_d;

    assign w_arb_en = ~i_hold & ~i_rst;

    rr_arbiter #(
        .N   (N_REQ)
    ) u_rr_arbiter (
        .req (i_req_valid),
        .ptr (r_ptr_q),
        .en  (w_arb_en),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    // ROM address is combinational: the ROM itself registers it.
    always_comb begin
        w_accept    = |w_gnt;
        o_req_ready = w_gnt;
        o_mem_valid = w_accept;
        o_mem_addr  = '0;
        w_ptr_d     = r_ptr_q;
        w_s1_vld_d  = '0;
        w_s1_tag_d  = '0;
        if (w_accept) begin
            o_mem_addr = i_req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
            w_ptr_d    = (int'(w_idx) == N_REQ - 1) ? '0 : PTR_W'(int'(w_idx) + 1);
            w_s1_vld_d = w_gnt;
            w_s1_tag_d = i_req_tag[int'(w_idx)*TAG_W +: TAG_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr_q    <= '0;
            r_s1_vld_q <= '0;
            r_s1_tag_q <= '0;
        end else begin
            r_ptr_q    <= w_ptr_d;
            r_s1_vld_q <= w_s1_vld_d;
            r_s1_tag_q <= w_s1_tag_d;
        end
    end

`ifdef COEF_ARB_RSP_REG_EN
    logic [N_REQ-1:0]  r_s2_vld_q;
    logic [N_REQ-1:0]  w_s2_vld_d;
    logic [TAG_W-1:0]  r_s2_tag_q;
    logic [TAG_W-1:0]  w_s2_tag_d;
    logic [DATA_W-1:0] r_s2_data_q;
    logic [DATA_W-1:0] w_s2_data_d;

    always_comb begin
        w_s2_vld_d  = r_s1_vld_q;
        w_s2_tag_d  = r_s1_tag_q;
        w_s2_data_d = i_mem_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_vld_q  <= '0;
            r_s2_tag_q  <= '0;
            r_s2_data_q <= '0;
        end else begin
            r_s2_vld_q  <= w_s2_vld_d;
            r_s2_tag_q  <= w_s2_tag_d;
            r_s2_data_q <= w_s2_data_d;
        end
    end

    assign o_rsp_valid = r_s2_vld_q;
    assign o_rsp_tag   = r_s2_tag_q;
    assign o_rsp_data  = r_s2_data_q;
    assign o_busy      = (|r_s1_vld_q) | (|r_s2_vld_q);
`else
    assign o_rsp_valid = r_s1_vld_q;
    assign o_rsp_tag   = r_s1_tag_q;
    assign o_rsp_data  = i_mem_data;
    assign o_busy      = |r_s1_vld_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coef_rom_arbiter.sv
// ============================================================================
// Module  : tb_coef_rom_arbiter
// Brief   : Self-checking bench for coef_rom_arbiter with a ROM model and a
//           queue-based reference of grants and pending responses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coef_rom_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 168;
    localparam int TW = 4;
`ifdef COEF_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*TW-1:0] req_tag;
    logic [N-1:0]    req_ready;
    logic            hold;
    logic [AW-1:0]   mem_addr;
    logic            mem_valid;
    logic [DW-1:0]   mem_data;
    logic [N-1:0]    rsp_valid;
    logic [TW-1:0]   rsp_tag;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    always #5 clk = ~clk;

    coef_rom_arbiter #(
        .N_REQ       (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TAG_W       (TW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .i_req_tag   (req_tag),
        .o_req_ready (req_ready),
        .i_hold      (hold),
        .o_mem_addr  (mem_addr),
        .o_mem_valid (mem_valid),
        .i_mem_data  (mem_data),
        .o_rsp_valid (rsp_valid),
        .o_rsp_tag   (rsp_tag),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy)
    );

    // Synchronous ROM: registered address, one-cycle read latency.
    logic [DW-1:0] rom [32];
    logic [AW-1:0] rom_addr_q = '0;
    always_ff @(posedge clk) rom_addr_q <= mem_addr;
    assign mem_data = rom[rom_addr_q];

    typedef struct {
        int            due;
        logic [N-1:0]  oh;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t q[$];
    int   m_ptr  = 0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step(input logic [N-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [TW-1:0] t0, input logic [TW-1:0] t1, input logic h, input logic r);
        int            k;
        logic [AW-1:0] aa [N];
        logic [TW-1:0] tt [N];
        logic [N-1:0]  exp_ready;
        logic [AW-1:0] exp_addr;
        logic [N-1:0]  exp_v;
        logic          exp_busy;
        rsp_t          e;
        aa[0] = a0; aa[1] = a1;
        tt[0] = t0; tt[1] = t1;
        req_valid = v;
        req_addr  = {a1, a0};
        req_tag   = {t1, t0};
        hold      = h;
        rst       = r;
        @(negedge clk);
        k = -1;
        if (!r && !h) begin
            for (int i = 0; i < N; i++) begin
                if (k < 0 && v[(m_ptr + i) % N]) k = (m_ptr + i) % N;
            end
        end
        exp_ready = '0;
        exp_addr  = '0;
        if (k >= 0) begin
            exp_ready[k] = 1'b1;
            exp_addr     = aa[k];
        end
        chk("ready", DW'(req_ready), DW'(exp_ready));
        chk("mem_valid", DW'(mem_valid), DW'(k >= 0));
        chk("mem_addr", DW'(mem_addr), DW'(exp_addr));
        exp_v    = '0;
        exp_busy = 1'b0;
        foreach (q[i]) begin
            if (q[i].due >= cyc && q[i].due <= cyc + LAT - 1) exp_busy = 1'b1;
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e     = q.pop_front();
            exp_v = e.oh;
            chk("rsp_tag", DW'(rsp_tag), DW'(e.tag));
            chk("rsp_data", rsp_data, e.data);
        end
        chk("rsp_valid", DW'(rsp_valid), DW'(exp_v));
        chk("busy", DW'(busy), DW'(exp_busy));
        if (r) begin
            q.delete();
            m_ptr = 0;
        end else if (k >= 0) begin
            e.due  = cyc + LAT;
            e.oh   = exp_ready;
            e.tag  = tt[k];
            e.data = rom[aa[k]];
            q.push_back(e);
            m_ptr = (k + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom[i] = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        end
        req_valid = '0;
        req_addr  = '0;
        req_tag   = '0;
        hold      = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset cycle: ready forced low even with requests present.
        step(2'b11, 5'd1, 5'd2, 4'd1, 4'd2, 1'b0, 1'b1);

        // Single requester 0, addr 5 tag 3.
        step(2'b01, 5'd5, 5'd0, 4'd3, 4'd0, 1'b0, 1'b0);
        idle(LAT);

        // Both continuously valid: strict alternation.
        for (int i = 0; i < 6; i++) step(2'b11, 5'd7, 5'd9, 4'd4, 4'd6, 1'b0, 1'b0);
        idle(LAT);

        // Hold while both valid, then release.
        step(2'b11, 5'd7, 5'd9, 4'd1, 4'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b11, 5'd7, 5'd9, 4'd1, 4'd2, 1'b1, 1'b0);
        step(2'b11, 5'd7, 5'd9, 4'd1, 4'd2, 1'b0, 1'b0);
        idle(LAT);

        // Accept requester 1 at address 31, reset the next cycle.
        step(2'b10, 5'd0, 5'd31, 4'd0, 4'd5, 1'b0, 1'b0);
        step(2'b00, 5'd0, 5'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        chk("post_rst_tag", DW'(rsp_tag), '0);
        chk("post_rst_valid", DW'(rsp_valid), '0);
        chk("post_rst_busy", DW'(busy), '0);
        step(2'b11, 5'd3, 5'd4, 4'd7, 4'd8, 1'b0, 1'b0);
        idle(LAT);

        // Requester 1 alone, addresses 0..31 back to back.
        for (int i = 0; i < 32; i++) step(2'b10, 5'd0, AW'(i), 4'd0, TW'(i), 1'b0, 1'b0);
        idle(LAT);

        // Randomized traffic, occasional hold and reset.
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom()), AW'($urandom()), AW'($urandom()), TW'($urandom()), TW'($urandom()),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0));
        end
        idle(LAT + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/coef_rom_arbiter.md
Name: coef_rom_arbiter

Overview:
- Shares one synchronous coefficient ROM (5-bit address, 168-bit word, registered address, 1-cycle read latency) between N_REQ requesters, e.g. the sin and cos evaluation lanes of the fsincos datapath.
- Performs round-robin arbitration with a valid/ready handshake per requester.
- Drives the ROM address and valid.
- Returns each ROM word to its originating requester, with that requester's tag, aligned to ROM latency.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- ADDR_W, 5, ROM address width.
- DATA_W, 168, ROM word width.
- TAG_W, 4, opaque per-request tag width, returned with the response.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset: synchronous, active-high.
- i_req_valid  input  N_REQ  request valid, one bit per requester.
- i_req_addr  input  N_REQ*ADDR_W  packed request addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- i_req_tag  input  N_REQ*TAG_W  packed request tags.
- o_req_ready  output  N_REQ  one-hot grant; a request is accepted when valid&ready.
- i_hold  input  1  stall; no grant is issued while high.
- o_mem_addr  output  ADDR_W  to ROM ADDR.
- o_mem_valid  output  1  to ROM i_valid.
- i_mem_data  input  DATA_W  from ROM COF_DATA_S.
- o_rsp_valid  output  N_REQ  one-hot response strobe.
- o_rsp_tag  output  TAG_W  tag of the current response.
- o_rsp_data  output  DATA_W  coefficient word.
- o_busy  output  1  high while any response is in flight.

Behaviour:
- Reset (i_rst high at a clock edge):
  - rr_ptr=0; o_rsp_valid=0; o_rsp_tag=0; in-flight pipeline cleared; o_busy=0.
  - o_req_ready is forced 0 during the reset cycle.
- Arbitration (combinational, cycle N):
  - Search i_req_valid starting at index rr_ptr, wrapping modulo N_REQ.
  - The first set bit k wins, and o_req_ready[k]=1 only if i_hold=0 and i_rst=0.
  - At most one ready bit is set.
- ROM drive:
  - On accept: o_mem_valid=1 and o_mem_addr=i_req_addr of k.
  - Otherwise: o_mem_valid=0 and o_mem_addr=0.
  - Both outputs are purely combinational, because the ROM registers the address itself.
- Pointer:
  - On accept of k, rr_ptr <= (k+1) mod N_REQ.
  - With no accept, rr_ptr holds.
  - A requester that holds valid continuously is granted at least once every N_REQ accepts.
- Response (latency 1):
  - The accept in cycle N registers a one-hot grant vector and the tag.
  - In cycle N+1: o_rsp_valid = registered grant, o_rsp_tag = registered tag, o_rsp_data = i_mem_data (pass-through).
- No response backpressure: the requester must consume in the strobe cycle.
- Back-to-back accepts every cycle are allowed, giving full throughput of 1 word/cycle.
- o_busy = |o_rsp_valid.
- When o_rsp_valid=0, o_rsp_data is don't-care (the ROM outputs entry 0).
- Boundary conditions:
  - All requesters valid simultaneously: strict rotation 0,1,...,N_REQ-1,0.
  - i_hold rising mid-stream: no new accept; the in-flight response still completes next cycle.
  - Reset mid-operation: the in-flight response is dropped; o_rsp_valid=0 in the cycle after reset.
  - A single active requester is granted every cycle regardless of rr_ptr.
  - Address 31 and address 0 pass through unmodified (no wrap logic on the address).

Optional Feature:
- Macro COEF_ARB_RSP_REG_EN.
- Defined: o_rsp_data, o_rsp_valid and o_rsp_tag pass through one extra register stage.
  - Latency becomes 2 cycles from accept.
  - Throughput is still 1/cycle.
  - o_busy covers both stages.
  - Reset clears both stages.
- Undefined: latency 1, with the data path combinational from i_mem_data as described above.

Decomposition:
- Shared package (fsincos_pkg):
  - ADDR_W=5 and DATA_W=168 constants.
  - ROM depth 32.
  - Latency constant COEF_ARB_LAT (1, or 2 when the macro is defined).
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, ptr, en.
  - Outputs: one-hot gnt, plus encoded idx.
  - Purely combinational, reused by other shared resources.
- The top level holds rr_ptr, the response pipeline and the ROM interface.

Test Plan:
- Reset, then requester 0 alone with addr=5, tag=3 → o_mem_valid=1 and o_mem_addr=5 in the same cycle; next cycle o_rsp_valid=2'b01, o_rsp_tag=3, o_rsp_data=ROM[5].
- Both valid continuously, addrs 7 and 9, for 6 cycles → grants alternate 0,1,0,1,0,1; responses follow 1 cycle later with ROM[7] and ROM[9] respectively.
- Both valid with i_hold=1 for 3 cycles → o_req_ready=0, o_mem_valid=0, o_mem_addr=0; rr_ptr unchanged; on release requester rr_ptr wins first.
- Accept requester 1 at addr=31, then assert i_rst the next cycle → no o_rsp_valid after reset; rr_ptr=0; o_busy=0.
- Requester 1 only, addr 0..31 back-to-back → 32 consecutive responses, each matching ROM[i], with no bubbles.
- Same as test 1 with COEF_ARB_RSP_REG_EN defined → response appears 2 cycles after accept; a back-to-back stream shows no gaps.
